// File: rtl/alu_pkg.sv
// Shared ALU definitions: serial-subtract FSM states and the slice width.
package alu_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sub_4bit.sv
// Combinational 4-bit borrow-lookahead subtract slice: d = a - b - bin.
module sub_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Subtraction as a + ~b + ~bin, so the add slice's carry terms apply directly.
    always_comb begin
        g    = a & ~b;
        p    = a ^ ~b;
        c[0] = ~bin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
        d    = p ^ c[3:0];
        bout = ~c[4];
    end

endmodule

// File: rtl/sub_8bit_serial.sv
// Nibble-serial subtract-with-borrow unit with valid/ready handshakes and
// borrow/zero/negative/signed-overflow flags.
module sub_8bit_serial
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int unsigned NIB  = WIDTH / NIB_W;
    localparam int unsigned IDXW = $clog2(NIB);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              borrow_q, borrow_d;
    logic              bout_q, bout_d;
    logic              zero_q, zero_d;
    logic              neg_q, neg_d;
    logic              ovf_q, ovf_d;

    logic [NIB_W-1:0]  sl_a, sl_b, sl_d;
    logic              sl_bout;

    assign sl_a = a_q[NIB_W*idx_q +: NIB_W];
    assign sl_b = b_q[NIB_W*idx_q +: NIB_W];

    sub_4bit u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .bin  (borrow_q),
        .d    (sl_d),
        .bout (sl_bout)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        d_d       = d_q;
        idx_d     = idx_q;
        borrow_d  = borrow_q;
        bout_d    = bout_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    idx_d    = '0;
                    borrow_d = bin;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                d_d[NIB_W*idx_q +: NIB_W] = sl_d;
                borrow_d = sl_bout;
                idx_d    = idx_q + IDXW'(1);
                // Flags come from d_d so the final nibble is already included.
                if (idx_q == IDXW'(NIB - 1)) begin
                    bout_d  = sl_bout;
                    zero_d  = (d_d == '0);
                    neg_d   = d_d[WIDTH-1];
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (d_d[WIDTH-1] != a_q[WIDTH-1]);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            d_q      <= d_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
        end
    end

    assign d    = d_q;
    assign bout = bout_q;
    assign zero = zero_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_sub_8bit_serial.sv
// Directed and randomized checks of sub_8bit_serial against an arithmetic
// reference model (WIDTH=8).
module tb_sub_8bit_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       bin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] d;
    logic       bout, zero, neg, ovf;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    sub_8bit_serial #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer subtraction; borrow is a negative true result.
    task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin,
                         output logic [7:0] md, output logic mbo, output logic mz,
                         output logic mn, output logic mo);
        int r;
        r   = int'(ma) - int'(mb) - int'(mbin);
        mbo = (r < 0);
        md  = 8'((r + 512) % 256);
        mz  = (md == 8'h00);
        mn  = md[7];
        mo  = (ma[7] != mb[7]) && (md[7] != ma[7]);
    endtask

    // Called at a negedge; returns at a negedge with the unit back in IDLE.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                         input int unsigned hold);
        logic [7:0]  ed;
        logic        eb, ez, en, eo;
        int unsigned lat;
        int unsigned waits;
        model(ta, tb_, tbin, ed, eb, ez, en, eo);
        waits = 0;
        while (!in_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check("in_ready_idle", in_ready, 1);
        a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        check("out_valid_calc", out_valid, 0);
        check("in_ready_calc", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 2);
        check("d", d, ed);
        check("bout", bout, eb);
        check("zero", zero, ez);
        check("neg", neg, en);
        check("ovf", ovf, eo);
        for (int unsigned i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_d", d, ed);
            check("hold_flags", {bout, zero, neg, ovf}, {eb, ez, en, eo});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_released", out_valid, 0);
        check("in_ready_released", in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_d", d, 0);
        check("rst_flags", {bout, zero, neg, ovf}, 4'b0000);

        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_out_ready_valid", out_valid, 0);
        check("idle_out_ready_ready", in_ready, 1);

        do_op(8'h35, 8'h12, 1'b0, 0);
        do_op(8'h10, 8'h01, 1'b0, 0);
        do_op(8'h00, 8'h01, 1'b0, 0);
        do_op(8'h80, 8'h01, 1'b0, 0);
        do_op(8'h7F, 8'hFF, 1'b0, 0);
        do_op(8'h42, 8'h41, 1'b1, 0);
        do_op(8'h05, 8'h05, 1'b1, 0);
        do_op(8'h80, 8'h00, 1'b1, 0);
        do_op(8'h9C, 8'h3A, 1'b0, 3);

        a = 8'h35; b = 8'h12; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_d", d, 0);
        @(negedge clk);
        check("midrst_still_idle", out_valid, 0);
        do_op(8'h35, 8'h12, 1'b0, 0);

        for (int k = 0; k < 25; k++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
